// File: rtl/psram_pkg.sv
// -----------------------------------------------------------------------------
// psram_pkg
// Shared definitions for the asynchronous-mode PSRAM controller:
//   - address / data widths of the PSRAM word interface
//   - default timing constants (in clk cycles)
//   - controller state encoding
//   - small elaboration-time helpers used to size counters
// -----------------------------------------------------------------------------
package psram_pkg;

   localparam int ADDR_W = 23;
   localparam int DATA_W = 16;

   localparam int DEF_RD_CYCLES      = 6;
   localparam int DEF_WR_CYCLES      = 6;
   localparam int DEF_GAP_CYCLES     = 1;
   localparam int DEF_RECOVERY       = 2;
   localparam int DEF_BURST_LEN      = 4;
   localparam int DEF_POWERUP_CYCLES = 7500;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      RD,
      WR,
      GAP,
      RECOV
   } state_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to hold the values 0 .. max_val-1.
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val);
   endfunction

endpackage

// File: rtl/psram_controller_if.sv
// -----------------------------------------------------------------------------
// psram_controller_if
// Request/response bus between the arbiter (master) and the PSRAM
// controller (slave).
//   app_data_out  write data, sampled at the start of each write word
//   app_addr      word address, sampled at acceptance
//   app_wr/app_rd request levels (write wins when both are high)
//   app_ub/app_lb byte-lane enables, active high, sampled at acceptance
//   app_burst     1 = burst request, 0 = single word
//   op_begun      1-cycle pulse: request accepted
//   data_ok       1-cycle pulse per completed word
//   op_finished   1-cycle pulse together with the last data_ok
//   rd_data       last word read
//   ctrl_good     power-up complete
// -----------------------------------------------------------------------------
interface psram_controller_if;
   import psram_pkg::*;

   logic [DATA_W-1:0] app_data_out;
   logic [ADDR_W-1:0] app_addr;
   logic              app_wr;
   logic              app_rd;
   logic              app_ub;
   logic              app_lb;
   logic              app_burst;
   logic              op_begun;
   logic              data_ok;
   logic              op_finished;
   logic [DATA_W-1:0] rd_data;
   logic              ctrl_good;

   modport master (
      output app_data_out, app_addr, app_wr, app_rd, app_ub, app_lb, app_burst,
      input  op_begun, data_ok, op_finished, rd_data, ctrl_good
   );

   modport slave (
      input  app_data_out, app_addr, app_wr, app_rd, app_ub, app_lb, app_burst,
      output op_begun, data_ok, op_finished, rd_data, ctrl_good
   );

endinterface

// File: rtl/psram_timer.sv
// -----------------------------------------------------------------------------
// psram_timer
// Loadable down-counter that stops at zero. Shared by the power-up wait,
// the per-word access time, the inter-word gap and the recovery time.
//   clk, reset_n  clock, asynchronous active-low reset (count = RESET_VAL)
//   load          load load_val this cycle (takes priority over counting)
//   load_val      value to load
//   count         current count
//   done          count has reached zero
// A load of N-1 therefore yields N clocks before the owning state sees done
// on its final edge.
// -----------------------------------------------------------------------------
module psram_timer #(
   parameter int unsigned     W         = 13,
   parameter logic [W-1:0]    RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         done
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= RESET_VAL;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign done  = (count_q == '0);

endmodule

// File: rtl/psram_controller.sv
// -----------------------------------------------------------------------------
// psram_controller
// Memory-side responder for the arbiter request bus. Accepts one single-word
// or burst read/write request at a time and sequences asynchronous-mode
// PSRAM pin timing for it.
//   clk, reset_n  clock, asynchronous active-low reset
//   app           request/response bus (slave side)
//   mem_addr      PSRAM word address
//   mem_dq_i      data from the pads
//   mem_dq_o      data to the pads, mem_dq_oe = 1 drives the pads
//   mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n   active-low strobes
//   mem_adv_n, mem_clk, mem_cre   tied low (asynchronous mode)
// Every output is a flop, so all outputs fall back to their idle values
// the instant reset_n goes low, even in the middle of an access.
// -----------------------------------------------------------------------------
module psram_controller
   import psram_pkg::*;
#(
   parameter int RD_CYCLES      = DEF_RD_CYCLES,
   parameter int WR_CYCLES      = DEF_WR_CYCLES,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int RECOVERY       = DEF_RECOVERY,
   parameter int BURST_LEN      = DEF_BURST_LEN,
   parameter int POWERUP_CYCLES = DEF_POWERUP_CYCLES
) (
   input  logic              clk,
   input  logic              reset_n,
   psram_controller_if.slave app,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_dq_i,
   output logic [DATA_W-1:0] mem_dq_o,
   output logic              mem_dq_oe,
   output logic              mem_ce_n,
   output logic              mem_oe_n,
   output logic              mem_we_n,
   output logic              mem_ub_n,
   output logic              mem_lb_n,
   output logic              mem_adv_n,
   output logic              mem_clk,
   output logic              mem_cre
);

   localparam int TMR_MAX = max2(max2(max2(POWERUP_CYCLES, RD_CYCLES),
                                      max2(WR_CYCLES, GAP_CYCLES)), RECOVERY);
   localparam int TW = cnt_w(TMR_MAX);
   localparam int IW = cnt_w(BURST_LEN);

   localparam logic [TW-1:0] T_POWERUP = TW'(POWERUP_CYCLES - 1);
   localparam logic [TW-1:0] T_RD      = TW'(RD_CYCLES - 1);
   localparam logic [TW-1:0] T_WR      = TW'(WR_CYCLES - 1);
   localparam logic [TW-1:0] T_GAP     = TW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0] T_REC     = TW'(RECOVERY - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(BURST_LEN - 1);

   state_e            state_q, state_d;
   logic              ctrl_good_q, ctrl_good_d;
   logic              op_begun_q, op_begun_d;
   logic              data_ok_q, data_ok_d;
   logic              op_finished_q, op_finished_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] dq_o_q, dq_o_d;
   logic              dq_oe_q, dq_oe_d;
   logic              ce_n_q, ce_n_d;
   logic              oe_n_q, oe_n_d;
   logic              we_n_q, we_n_d;
   logic              ub_n_q, ub_n_d;
   logic              lb_n_q, lb_n_d;

   // Request fields captured at acceptance; held for the whole operation.
   logic [ADDR_W-1:0] base_q, base_d;
   logic              ub_req_q, ub_req_d;
   logic              lb_req_q, lb_req_d;
   logic              burst_q, burst_d;
   logic              is_wr_q, is_wr_d;
   logic [IW-1:0]     idx_q, idx_d;

   logic              tmr_load;
   logic [TW-1:0]     tmr_val;
   logic [TW-1:0]     tmr_cnt;
   logic              tmr_done;

   // Word start/end requests raised by the state decode, applied once below.
   logic              start_word;
   logic              start_wr;
   logic [ADDR_W-1:0] start_addr;
   logic              start_ub;
   logic              start_lb;
   logic              end_word;

   psram_timer #(
      .W         (TW),
      .RESET_VAL (T_POWERUP)
   ) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .count    (tmr_cnt),
      .done     (tmr_done)
   );

   always_comb begin
      state_d       = state_q;
      ctrl_good_d   = ctrl_good_q;
      op_begun_d    = 1'b0;
      data_ok_d     = 1'b0;
      op_finished_d = 1'b0;
      rd_data_d     = rd_data_q;
      addr_d        = addr_q;
      dq_o_d        = dq_o_q;
      dq_oe_d       = dq_oe_q;
      ce_n_d        = ce_n_q;
      oe_n_d        = oe_n_q;
      we_n_d        = we_n_q;
      ub_n_d        = ub_n_q;
      lb_n_d        = lb_n_q;
      base_d        = base_q;
      ub_req_d      = ub_req_q;
      lb_req_d      = lb_req_q;
      burst_d       = burst_q;
      is_wr_d       = is_wr_q;
      idx_d         = idx_q;
      tmr_load      = 1'b0;
      tmr_val       = '0;
      start_word    = 1'b0;
      start_wr      = 1'b0;
      start_addr    = '0;
      start_ub      = 1'b0;
      start_lb      = 1'b0;
      end_word      = 1'b0;

      case (state_q)
         INIT: begin
            // The timer comes out of reset preloaded with the power-up count.
            if (tmr_done) begin
               state_d     = IDLE;
               ctrl_good_d = 1'b1;
            end
         end
         IDLE: begin
            if (app.app_wr || app.app_rd) begin
               base_d     = app.app_addr;
               ub_req_d   = app.app_ub;
               lb_req_d   = app.app_lb;
               burst_d    = app.app_burst;
               is_wr_d    = app.app_wr;
               idx_d      = '0;
               op_begun_d = 1'b1;
               start_word = 1'b1;
               start_wr   = app.app_wr;
               start_addr = app.app_addr;
               start_ub   = app.app_ub;
               start_lb   = app.app_lb;
            end
         end
         RD: begin
            if (tmr_done) begin
               rd_data_d = mem_dq_i;
               end_word  = 1'b1;
            end
         end
         WR: begin
            // Release WE# one clock early so the last cycle of the word is a
            // hold cycle with address and data still driven.
            if (tmr_cnt == TW'(1)) begin
               we_n_d = 1'b1;
            end
            if (tmr_done) begin
               end_word = 1'b1;
            end
         end
         GAP: begin
            if (tmr_done) begin
               start_word = 1'b1;
               start_wr   = is_wr_q;
               start_addr = base_q + ADDR_W'(idx_q);
               start_ub   = ub_req_q;
               start_lb   = lb_req_q;
            end
         end
         RECOV: begin
            // Requests are ignored here so a requester that drops its level
            // one cycle late cannot retrigger the finished operation.
            if (tmr_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = INIT;
         end
      endcase

      if (start_word) begin
         state_d  = start_wr ? WR : RD;
         addr_d   = start_addr;
         ce_n_d   = 1'b0;
         oe_n_d   = start_wr;
         we_n_d   = ~start_wr;
         ub_n_d   = ~start_ub;
         lb_n_d   = ~start_lb;
         dq_oe_d  = start_wr;
         if (start_wr) begin
            dq_o_d = app.app_data_out;
         end
         tmr_load = 1'b1;
         tmr_val  = start_wr ? T_WR : T_RD;
      end

      if (end_word) begin
         ce_n_d    = 1'b1;
         oe_n_d    = 1'b1;
         we_n_d    = 1'b1;
         ub_n_d    = 1'b1;
         lb_n_d    = 1'b1;
         dq_oe_d   = 1'b0;
         data_ok_d = 1'b1;
         tmr_load  = 1'b1;
         if (burst_q && (idx_q != LAST_IDX)) begin
            state_d = GAP;
            idx_d   = idx_q + 1'b1;
            tmr_val = T_GAP;
         end else begin
            state_d       = RECOV;
            op_finished_d = 1'b1;
            tmr_val       = T_REC;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= INIT;
         ctrl_good_q   <= 1'b0;
         op_begun_q    <= 1'b0;
         data_ok_q     <= 1'b0;
         op_finished_q <= 1'b0;
         rd_data_q     <= '0;
         addr_q        <= '0;
         dq_o_q        <= '0;
         dq_oe_q       <= 1'b0;
         ce_n_q        <= 1'b1;
         oe_n_q        <= 1'b1;
         we_n_q        <= 1'b1;
         ub_n_q        <= 1'b1;
         lb_n_q        <= 1'b1;
         base_q        <= '0;
         ub_req_q      <= 1'b0;
         lb_req_q      <= 1'b0;
         burst_q       <= 1'b0;
         is_wr_q       <= 1'b0;
         idx_q         <= '0;
      end else begin
         state_q       <= state_d;
         ctrl_good_q   <= ctrl_good_d;
         op_begun_q    <= op_begun_d;
         data_ok_q     <= data_ok_d;
         op_finished_q <= op_finished_d;
         rd_data_q     <= rd_data_d;
         addr_q        <= addr_d;
         dq_o_q        <= dq_o_d;
         dq_oe_q       <= dq_oe_d;
         ce_n_q        <= ce_n_d;
         oe_n_q        <= oe_n_d;
         we_n_q        <= we_n_d;
         ub_n_q        <= ub_n_d;
         lb_n_q        <= lb_n_d;
         base_q        <= base_d;
         ub_req_q      <= ub_req_d;
         lb_req_q      <= lb_req_d;
         burst_q       <= burst_d;
         is_wr_q       <= is_wr_d;
         idx_q         <= idx_d;
      end
   end

   assign app.op_begun    = op_begun_q;
   assign app.data_ok     = data_ok_q;
   assign app.op_finished = op_finished_q;
   assign app.rd_data     = rd_data_q;
   assign app.ctrl_good   = ctrl_good_q;

   assign mem_addr  = addr_q;
   assign mem_dq_o  = dq_o_q;
   assign mem_dq_oe = dq_oe_q;
   assign mem_ce_n  = ce_n_q;
   assign mem_oe_n  = oe_n_q;
   assign mem_we_n  = we_n_q;
   assign mem_ub_n  = ub_n_q;
   assign mem_lb_n  = lb_n_q;
   assign mem_adv_n = 1'b0;
   assign mem_clk   = 1'b0;
   assign mem_cre   = 1'b0;

endmodule

// File: tb/tb_psram_controller.sv
// -----------------------------------------------------------------------------
// tb_psram_controller
// Randomized bench for psram_controller. A behavioural PSRAM pad model holds
// what the pins actually wrote; a reference memory plus arithmetic timing
// (word k of a C-cycle access occupies cycles 1+k*(C+GAP) .. +C-1 after the
// acceptance edge, its data_ok lands at C+1+k*(C+GAP)) gives every expected
// value.
// -----------------------------------------------------------------------------
module tb_psram_controller;
   import psram_pkg::*;

   localparam int C_RD  = DEF_RD_CYCLES;
   localparam int C_WR  = DEF_WR_CYCLES;
   localparam int C_GAP = DEF_GAP_CYCLES;
   localparam int C_BL  = DEF_BURST_LEN;
   localparam int C_PWR = DEF_POWERUP_CYCLES;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_dq_i = '0;
   logic [DATA_W-1:0] mem_dq_o;
   logic              mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n;
   logic              mem_adv_n, mem_clk, mem_cre;

   psram_controller_if app_if ();

   psram_controller dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .app       (app_if),
      .mem_addr  (mem_addr),
      .mem_dq_i  (mem_dq_i),
      .mem_dq_o  (mem_dq_o),
      .mem_dq_oe (mem_dq_oe),
      .mem_ce_n  (mem_ce_n),
      .mem_oe_n  (mem_oe_n),
      .mem_we_n  (mem_we_n),
      .mem_ub_n  (mem_ub_n),
      .mem_lb_n  (mem_lb_n),
      .mem_adv_n (mem_adv_n),
      .mem_clk   (mem_clk),
      .mem_cre   (mem_cre)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- memories: pad model and reference ----------------
   logic [15:0] pad_mem [int unsigned];
   logic [15:0] ref_mem [int unsigned];

   function automatic logic [15:0] fill(input logic [22:0] a);
      return a[15:0] ^ {a[22:16], 9'h0A5};
   endfunction

   function automatic logic [15:0] pad_read(input logic [22:0] a);
      int unsigned key = 32'(a);
      if (pad_mem.exists(key)) return pad_mem[key];
      return fill(a);
   endfunction

   function automatic logic [15:0] ref_read(input logic [22:0] a);
      int unsigned key = 32'(a);
      if (ref_mem.exists(key)) return ref_mem[key];
      return fill(a);
   endfunction

   // Asynchronous PSRAM: drives data while CE#/OE# low, latches on WE# rise.
   always @(mem_ce_n or mem_oe_n or mem_addr) begin
      mem_dq_i = (!mem_ce_n && !mem_oe_n) ? pad_read(mem_addr) : 16'h0000;
   end

   always @(posedge mem_we_n) begin
      logic [15:0] w;
      logic [15:0] bus;
      if (mem_ce_n === 1'b0) begin
         w   = pad_read(mem_addr);
         bus = mem_dq_oe ? mem_dq_o : 16'hxxxx;
         if (!mem_ub_n) w[15:8] = bus[15:8];
         if (!mem_lb_n) w[7:0]  = bus[7:0];
         pad_mem[32'(mem_addr)] = w;
      end
   end

   // ---------------- helpers ----------------
   task automatic reset_values_check(input string tag);
      check_eq({tag, "_strobes"}, 32'({mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n, mem_dq_oe}), 32'h3E);
      check_eq({tag, "_pulses"}, 32'({app_if.op_begun, app_if.data_ok, app_if.op_finished, app_if.ctrl_good}), 32'h0);
      check_eq({tag, "_rd_data"}, 32'(app_if.rd_data), 32'h0);
      check_eq({tag, "_addr"}, 32'(mem_addr), 32'h0);
      check_eq({tag, "_dq_o"}, 32'(mem_dq_o), 32'h0);
      check_eq({tag, "_tied"}, 32'({mem_adv_n, mem_clk, mem_cre}), 32'h0);
   endtask

   // Called right after reset_n rises at a negedge; app_rd is held high the
   // whole time and must not start anything before ctrl_good.
   task automatic powerup_check();
      int cyc = 0;
      int bad = 0;
      app_if.app_wr = 1'b0;
      app_if.app_rd = 1'b1;
      while (cyc < C_PWR + 500) begin
         @(negedge clk);
         cyc++;
         if (mem_ce_n !== 1'b1 || mem_oe_n !== 1'b1 || mem_we_n !== 1'b1 || app_if.op_begun !== 1'b0)
            bad++;
         if (app_if.ctrl_good === 1'b1) break;
      end
      app_if.app_rd = 1'b0;
      check_eq("powerup_cycles", 32'(cyc), 32'(C_PWR));
      check_eq("powerup_quiet", 32'(bad), 32'h0);
      $display("powerup: ctrl_good after %0d clocks", cyc);
   endtask

   // One request, checked cycle by cycle. abort_at != 0 asserts reset at
   // that cycle and ends the transaction.
   task automatic run_txn(input bit wr, input logic [22:0] addr, input bit ub, input bit lb,
                          input bit burst, input logic [15:0] w0, input int abort_at);
      logic [15:0] wdata [16];
      logic [15:0] oldw, neww;
      logic [22:0] ea;
      logic [5:0]  exp_s;
      logic [2:0]  exp_p;
      int c_len, per, nw, fin, k, ph, dk;
      c_len = wr ? C_WR : C_RD;
      per   = c_len + C_GAP;
      nw    = burst ? C_BL : 1;
      fin   = c_len + 1 + (nw - 1) * per;
      for (int i = 0; i < 16; i++) wdata[i] = 16'($urandom);
      wdata[0] = w0;

      @(negedge clk);
      app_if.app_addr     = addr;
      app_if.app_ub       = ub;
      app_if.app_lb       = lb;
      app_if.app_burst    = burst;
      app_if.app_wr       = wr;
      app_if.app_rd       = wr ? 1'($urandom) : 1'b1;
      app_if.app_data_out = wdata[0];

      for (int cyc = 1; cyc <= fin + 3; cyc++) begin
         @(negedge clk);
         k = -1; ph = 0; dk = -1;
         for (int j = 0; j < nw; j++) begin
            if (cyc >= 1 + j * per && cyc < 1 + j * per + c_len) begin
               k  = j;
               ph = cyc - (1 + j * per);
            end
            if (cyc == c_len + 1 + j * per) dk = j;
         end
         if (k >= 0)
            exp_s = {1'b0, wr, (wr && ph < c_len - 1) ? 1'b0 : 1'b1, ~ub, ~lb, wr};
         else
            exp_s = 6'b111110;
         exp_p = {cyc == 1, dk >= 0, cyc == fin};
         check_eq("strobes", 32'({mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n, mem_dq_oe}), 32'(exp_s));
         check_eq("pulses", 32'({app_if.op_begun, app_if.data_ok, app_if.op_finished}), 32'(exp_p));
         if (k >= 0) begin
            ea = addr + 23'(k);
            check_eq("addr", 32'(mem_addr), 32'(ea));
            if (wr) check_eq("wdata", 32'(mem_dq_o), 32'(wdata[k]));
         end
         if (!wr && dk >= 0) begin
            ea = addr + 23'(dk);
            check_eq("rd_data", 32'(app_if.rd_data), 32'(ref_read(ea)));
         end

         if (cyc == abort_at) begin
            reset_n = 1'b0;
            #1;
            reset_values_check("abort");
            app_if.app_wr = 1'b0;
            app_if.app_rd = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check_eq("abort_quiet", 32'({app_if.data_ok, app_if.op_finished, mem_ce_n, mem_dq_oe}), 32'h2);
            end
            $display("txn aborted by reset wr=%0d addr=%06h at cycle %0d", wr, addr, cyc);
            return;
         end

         // Sampled fields may change freely once the request is accepted.
         if (cyc == 1) begin
            app_if.app_addr  = 23'($urandom);
            app_if.app_ub    = 1'($urandom);
            app_if.app_lb    = 1'($urandom);
            app_if.app_burst = 1'($urandom);
         end
         if (wr && k >= 0 && ph == 0) app_if.app_data_out = 16'($urandom);
         if (wr && dk >= 0 && dk < nw - 1) app_if.app_data_out = wdata[dk + 1];
         // Arbiter-style late deassert: level still high one cycle after op_finished.
         if (cyc == fin + 2) begin
            app_if.app_wr = 1'b0;
            app_if.app_rd = 1'b0;
         end
      end

      if (wr) begin
         for (int j = 0; j < nw; j++) begin
            ea   = addr + 23'(j);
            oldw = ref_read(ea);
            neww = {ub ? wdata[j][15:8] : oldw[15:8], lb ? wdata[j][7:0] : oldw[7:0]};
            ref_mem[32'(ea)] = neww;
            check_eq("memword", 32'(pad_read(ea)), 32'(neww));
         end
      end
      $display("txn %s addr=%06h burst=%0d ub=%0d lb=%0d words=%0d", wr ? "WR" : "RD", addr, burst, ub, lb, nw);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [15:0] v, f;
      logic [22:0] ra;
      bit          rwr, rburst;

      reset_n             = 1'b0;
      app_if.app_data_out = '0;
      app_if.app_addr     = '0;
      app_if.app_wr       = 1'b0;
      app_if.app_rd       = 1'b1;
      app_if.app_ub       = 1'b0;
      app_if.app_lb       = 1'b0;
      app_if.app_burst    = 1'b0;

      repeat (3) @(negedge clk);
      reset_values_check("reset");
      reset_n = 1'b1;
      powerup_check();

      // Directed: single read returning 0xBEEF.
      pad_mem[32'h123] = 16'hBEEF;
      ref_mem[32'h123] = 16'hBEEF;
      run_txn(1'b0, 23'h000123, 1'b1, 1'b1, 1'b0, 16'h0000, 0);
      check_eq("read_beef", 32'(app_if.rd_data), 32'hBEEF);

      // Directed: single upper-byte write of 0xA5A5.
      run_txn(1'b1, 23'h000010, 1'b1, 1'b0, 1'b0, 16'hA5A5, 0);
      v = pad_read(23'h000010);
      f = fill(23'h000010);
      check_eq("wr_upper_lane", 32'(v[15:8]), 32'hA5);
      check_eq("wr_lower_kept", 32'(v[7:0]), 32'(f[7:0]));

      // Directed: burst read wrapping past the top of the address space.
      run_txn(1'b0, 23'h7FFFFE, 1'b1, 1'b1, 1'b1, 16'h0000, 0);

      // Random mix, with a few reads-after-writes landing near the wrap point.
      for (int t = 0; t < 40; t++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         rwr    = 1'($urandom);
         rburst = 1'($urandom);
         if ($urandom_range(0, 3) == 0)
            ra = 23'h7FFFFF - 23'($urandom_range(0, 5));
         else if ($urandom_range(0, 2) == 0)
            ra = 23'($urandom_range(0, 7));
         else
            ra = 23'($urandom);
         run_txn(rwr, ra, 1'($urandom), 1'($urandom), rburst, 16'($urandom), 0);
      end

      // Reset in the middle of the second word of a burst write.
      run_txn(1'b1, 23'($urandom), 1'b1, 1'b1, 1'b1, 16'($urandom), 1 + (C_WR + C_GAP) + 2);
      @(negedge clk);
      reset_n = 1'b1;
      powerup_check();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
